vga_pmod_capture: RTL and testbench

Receive-side counterpart to the TinyVGA PMOD video output. Samples the 8-bit PMOD byte each pixel clock, locks to the 640x480@60 sync stream, and reconstructs pixel coordinates and the 2-bit RGB. Accumulates per-frame statistics, a lit-pixel count and a colour checksum, for on-board self-test and bench scoreboarding of the renderers.

---
 rtl/vga_pmod_capture_if.sv | 27 ++
 rtl/vga_pmod_capture.sv | 188 ++++++++++++++++++
 tb/tb_vga_pmod_capture.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pmod_capture_if.sv
// PMOD capture bus: raw PMOD byte in, recovered video timing/colour and frame statistics out.
interface vga_pmod_capture_if;
  logic [7:0]  i_pmod_in;
  logic [9:0]  o_hpos;
  logic [9:0]  o_vpos;
  logic        o_display_on;
  logic [1:0]  o_r;
  logic [1:0]  o_g;
  logic [1:0]  o_b;
  logic        o_locked;
  logic        o_frame_done;
  logic [18:0] o_lit_count;
  logic [15:0] o_frame_sum;
  logic        o_sync_err;

  modport master (
    output i_pmod_in,
    input  o_hpos, o_vpos, o_display_on, o_r, o_g, o_b,
    input  o_locked, o_frame_done, o_lit_count, o_frame_sum, o_sync_err
  );

  modport slave (
    input  i_pmod_in,
    output o_hpos, o_vpos, o_display_on, o_r, o_g, o_b,
    output o_locked, o_frame_done, o_lit_count, o_frame_sum, o_sync_err
  );
endinterface

// File: rtl/vga_pmod_capture.sv
// Receive side of the TinyVGA PMOD: locks to the sync stream, recovers pixel coordinates
// and colour, and reports a per-frame lit-pixel count and colour checksum.
module vga_pmod_capture #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input logic               clk,
  input logic               reset,
  vga_pmod_capture_if.slave io_cap
);
  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] HLoad    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HPre     = 10'(H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0] HLast    = 10'(HTotal - 1);
  localparam logic [9:0] HVis     = 10'(H_VISIBLE);
  localparam logic [9:0] HVisLast = 10'(H_VISIBLE - 1);
  localparam logic [9:0] VLoad    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VPre     = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0] VLast    = 10'(VTotal - 1);
  localparam logic [9:0] VVis     = 10'(V_VISIBLE);
  localparam logic [9:0] VVisLast = 10'(V_VISIBLE - 1);

  typedef enum logic [1:0] {StSearch, StHlock, StLocked} state_e;

  // Sample / timing-recovery stage
  logic [7:0] r_s1;
  logic       r_hs_prev;
  logic       r_vs_prev;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic [5:0] r_rgb;
  state_e     r_state;
  logic [1:0] r_good;
  logic       r_sync_err;

  // Output / statistics stage
  logic        r_armed;
  logic [18:0] r_acc_lit;
  logic [15:0] r_acc_sum;
  logic [9:0]  r_hpos;
  logic [9:0]  r_vpos;
  logic        r_display_on;
  logic [5:0]  r_rgb_out;
  logic        r_frame_done;
  logic [18:0] r_lit_count;
  logic [15:0] r_frame_sum;

  logic        w_hs_edge;
  logic        w_vs_edge;
  logic        w_hwrap;
  logic        w_h_on_time;
  logic        w_hs_err;
  logic        w_vs_err;
  logic [9:0]  w_hcnt_nxt;
  logic [9:0]  w_vcnt_nxt;
  logic [1:0]  w_good_nxt;
  logic        w_locked;
  logic        w_visible;
  logic        w_arm;
  logic        w_acc;
  logic        w_frame_end;
  logic [18:0] w_lit_nxt;
  logic [15:0] w_sum_nxt;

  assign w_hs_edge   = r_hs_prev & ~r_s1[7];
  assign w_vs_edge   = r_vs_prev & ~r_s1[3];
  assign w_hwrap     = ~w_hs_edge && (r_hcnt == HLast);
  assign w_h_on_time = (r_hcnt == HPre);
  // Off-time edge, or the edge that should land on this sample never came.
  assign w_hs_err    = w_hs_edge ? ~w_h_on_time : w_h_on_time;
  assign w_vs_err    = w_vs_edge && (r_vcnt != VPre);

  assign w_hcnt_nxt = w_hs_edge ? HLoad : (w_hwrap ? 10'd0 : r_hcnt + 10'd1);
  assign w_vcnt_nxt = w_vs_edge ? VLoad :
                      (w_hwrap ? ((r_vcnt == VLast) ? 10'd0 : r_vcnt + 10'd1) : r_vcnt);
  assign w_good_nxt = ~w_hs_edge ? r_good :
                      (~w_h_on_time ? 2'd0 : ((r_good == 2'd2) ? 2'd2 : r_good + 2'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 8'd0;
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_hcnt    <= 10'd0;
      r_vcnt    <= 10'd0;
      r_rgb     <= 6'd0;
    end else begin
      r_s1      <= io_cap.i_pmod_in;
      r_hs_prev <= r_s1[7];
      r_vs_prev <= r_s1[3];
      r_hcnt    <= w_hcnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_rgb     <= {r_s1[0], r_s1[4], r_s1[1], r_s1[5], r_s1[2], r_s1[6]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StSearch;
      r_good     <= 2'd0;
      r_sync_err <= 1'b0;
    end else begin
      case (r_state)
        StSearch: begin
          if (w_hs_edge) begin
            r_state <= StHlock;
            r_good  <= 2'd0;
          end
        end
        StHlock: begin
          // The hsync check of this sample counts before a coincident vsync is judged.
          r_good <= w_good_nxt;
          if (w_vs_edge && (w_good_nxt == 2'd2)) r_state <= StLocked;
        end
        StLocked: begin
          if (w_hs_err || w_vs_err) begin
            r_state    <= StSearch;
            r_good     <= 2'd0;
            r_sync_err <= 1'b1;
          end
        end
        default: r_state <= StSearch;
      endcase
    end
  end

  assign w_locked    = (r_state == StLocked);
  assign w_visible   = (r_hcnt < HVis) && (r_vcnt < VVis);
  assign w_arm       = w_locked && (r_armed || ((r_hcnt == 10'd0) && (r_vcnt == 10'd0)));
  assign w_acc       = w_arm && w_visible;
  assign w_lit_nxt   = r_acc_lit + {18'd0, (w_acc && (r_rgb != 6'd0))};
  assign w_sum_nxt   = r_acc_sum + {10'd0, (w_acc ? r_rgb : 6'd0)};
  assign w_frame_end = w_arm && (r_hcnt == HVisLast) && (r_vcnt == VVisLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed      <= 1'b0;
      r_acc_lit    <= 19'd0;
      r_acc_sum    <= 16'd0;
      r_hpos       <= 10'd0;
      r_vpos       <= 10'd0;
      r_display_on <= 1'b0;
      r_rgb_out    <= 6'd0;
      r_frame_done <= 1'b0;
      r_lit_count  <= 19'd0;
      r_frame_sum  <= 16'd0;
    end else begin
      r_armed      <= w_arm;
      r_hpos       <= r_hcnt;
      r_vpos       <= r_vcnt;
      r_display_on <= w_visible && w_locked;
      r_rgb_out    <= r_rgb;
      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        r_lit_count <= w_lit_nxt;
        r_frame_sum <= w_sum_nxt;
        r_acc_lit   <= 19'd0;
        r_acc_sum   <= 16'd0;
      end else if (!w_arm) begin
        // Anything gathered before arming belongs to a partial frame.
        r_acc_lit <= 19'd0;
        r_acc_sum <= 16'd0;
      end else begin
        r_acc_lit <= w_lit_nxt;
        r_acc_sum <= w_sum_nxt;
      end
    end
  end

  assign io_cap.o_hpos       = r_hpos;
  assign io_cap.o_vpos       = r_vpos;
  assign io_cap.o_display_on = r_display_on;
  assign io_cap.o_r          = r_rgb_out[5:4];
  assign io_cap.o_g          = r_rgb_out[3:2];
  assign io_cap.o_b          = r_rgb_out[1:0];
  assign io_cap.o_locked     = w_locked;
  assign io_cap.o_frame_done = r_frame_done;
  assign io_cap.o_lit_count  = r_lit_count;
  assign io_cap.o_frame_sum  = r_frame_sum;
  assign io_cap.o_sync_err   = r_sync_err;
endmodule

// File: tb/tb_vga_pmod_capture.sv
// Bench for vga_pmod_capture on a shrunken 48x24 raster so whole frames stay short.
module tb_vga_pmod_capture;
  localparam int HV = 48, HF = 4, HS = 8, HB = 4;
  localparam int VV = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HLd = HV + HF;
  localparam int VLd = VV + VF;
  localparam int DotH = 10, DotV = 5;
  localparam int PatBlack = 0, PatWhite = 1, PatDot = 2, PatBlue = 3, PatRed = 4, PatChk = 5;

  typedef struct {
    int pat;
    int exp_lit;
    int exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_pmod_capture_if cap();

  vga_pmod_capture #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_cap(cap)
  );

  int n_tests = 0, n_fail = 0;
  int step_n = 0;
  int gh = 0, gv = 0, pat = PatBlack;
  int early_line = -1;
  bit vs_early = 0;
  int hist_h[3] = '{-1, -1, -1};
  int hist_v[3] = '{-1, -1, -1};
  int fd_cnt = 0, fd_step = -1, fd_prev_step = -1, fd_h3 = -1, fd_v3 = -1;
  logic [18:0] fd_lit = '0;
  logic [15:0] fd_sum = '0;
  logic prev_locked = 1'b0;
  bit drv_vs_prev = 1'b1;
  int lock_rise_step = -1, vs_drive_step = -1;
  int unlock_step = -1, err_step = -1, early_drive_step = -1;
  bit dot_watch = 0, sim_watch = 0, rst_arm = 0, rst_chk = 0;
  int dot_hits = 0, sim_hits = 0, rst_h = 0, rst_v = 0;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pix_rgb(input int p, input int h, input int v);
    case (p)
      PatWhite: return 6'h3f;
      PatDot:   return (h == DotH && v == DotV) ? 6'h3f : 6'h00;
      PatBlue:  return 6'b000010;
      PatRed:   return 6'b110000;
      PatChk:   return (((h + v) % 2) == 0) ? 6'b010101 : 6'h00;
      default:  return 6'h00;
    endcase
  endfunction

  function automatic logic [7:0] pmod_byte(input int h, input int v);
    logic hs, vs;
    logic [5:0] c;
    hs = !(h >= HLd && h < HLd + HS);
    if (v == early_line && h == HLd - 1) hs = 1'b0;
    vs = !(v >= VLd && v < VLd + VS);
    if (vs_early && v == VLd - 1 && h >= HLd) vs = 1'b0;
    c = (h < HV && v < VV) ? pix_rgb(pat, h, v) : 6'h00;
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  // One pixel clock: observe outputs after the edge, then drive the next generator pixel.
  task automatic step();
    logic [7:0] byte_v;
    @(posedge clk);
    #1;
    step_n++;
    if (cap.o_frame_done) begin
      fd_cnt++;
      fd_lit = cap.o_lit_count;
      fd_sum = cap.o_frame_sum;
      fd_h3 = hist_h[2];
      fd_v3 = hist_v[2];
      fd_prev_step = fd_step;
      fd_step = step_n;
    end
    if (!prev_locked && cap.o_locked && lock_rise_step < 0) lock_rise_step = step_n;
    if (prev_locked && !cap.o_locked && unlock_step < 0) unlock_step = step_n;
    if (cap.o_sync_err && err_step < 0) err_step = step_n;
    prev_locked = cap.o_locked;
    if (rst_chk) begin
      rst_chk = 0;
      check("midreset_outputs", {cap.o_hpos, cap.o_vpos, cap.o_display_on, cap.o_r, cap.o_g,
            cap.o_b, cap.o_locked, cap.o_frame_done, cap.o_lit_count, cap.o_frame_sum}, 64'd0);
      check("midreset_sync_err", cap.o_sync_err, 0);
    end
    if (dot_watch && hist_h[2] == DotH && hist_v[2] == DotV) begin
      dot_hits++;
      check("dot_hpos", cap.o_hpos, DotH);
      check("dot_vpos", cap.o_vpos, DotV);
      check("dot_rgb", {cap.o_r, cap.o_g, cap.o_b}, 6'h3f);
      check("dot_display_on", cap.o_display_on, 1);
    end
    if (sim_watch && hist_h[2] == HLd && hist_v[2] == VLd - 1) begin
      sim_hits++;
      check("sim_hpos", cap.o_hpos, HLd);
      check("sim_vpos", cap.o_vpos, VLd);
      check("sim_locked", cap.o_locked, 1);
    end
    if (rst_arm && gh == rst_h && gv == rst_v) begin
      reset = 1'b1;
      rst_arm = 0;
      rst_chk = 1;
    end else begin
      reset = 1'b0;
    end
    byte_v = pmod_byte(gh, gv);
    cap.i_pmod_in = byte_v;
    if (drv_vs_prev && !byte_v[3] && vs_drive_step < 0) vs_drive_step = step_n;
    drv_vs_prev = byte_v[3];
    if (gv == early_line && gh == HLd - 1) early_drive_step = step_n;
    hist_h[2] = hist_h[1]; hist_v[2] = hist_v[1];
    hist_h[1] = hist_h[0]; hist_v[1] = hist_v[0];
    hist_h[0] = gh;        hist_v[0] = gv;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end
  endtask

  task automatic run_frame(input int p, input int v0);
    pat = p;
    fd_cnt = 0;
    gh = 0;
    gv = v0;
    for (int i = 0; i < (VT - v0) * HT; i++) step();
  endtask

  task automatic check_frame(input string tag, input int exp_lit, input int exp_sum);
    check({tag, "_done_count"}, fd_cnt, 1);
    check({tag, "_lit"}, fd_lit, exp_lit);
    check({tag, "_sum"}, fd_sum, exp_sum);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1152 visible pixels; white sum 72576 wraps to 7040.
    vecs[0] = '{PatWhite, 1152, 7040};
    vecs[1] = '{PatDot,   1,    63};
    vecs[2] = '{PatBlack, 0,    0};
    vecs[3] = '{PatBlue,  1152, 2304};
    vecs[4] = '{PatRed,   1152, 55296};

    reset = 1'b1;
    cap.i_pmod_in = 8'h88;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {cap.o_hpos, cap.o_vpos, cap.o_display_on, cap.o_r, cap.o_g,
          cap.o_b, cap.o_locked, cap.o_frame_done, cap.o_lit_count, cap.o_frame_sum}, 64'd0);
    check("reset_sync_err", cap.o_sync_err, 0);
    reset = 1'b0;

    // Acquisition: lock must come 2 clocks after the first vsync-low sample is driven.
    run_frame(PatBlack, 0);
    check("lock_latency", lock_rise_step - vs_drive_step, 2);
    check("lock_frame_no_done", fd_cnt, 0);
    check("locked_after_lock_frame", cap.o_locked, 1);

    for (int i = 0; i < 5; i++) begin
      dot_watch = (vecs[i].pat == PatDot);
      run_frame(vecs[i].pat, 0);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_lit, vecs[i].exp_sum);
      check($sformatf("vec%0d_done_pos", i), fd_h3 * 1000 + fd_v3, (HV - 1) * 1000 + VV - 1);
      if (i > 0) check($sformatf("vec%0d_done_period", i), fd_step - fd_prev_step, HT * VT);
    end
    dot_watch = 0;
    check("dot_seen", dot_hits, 1);

    // One early hsync edge on line 6 breaks lock; relock happens at this frame's vsync.
    early_line = 6;
    unlock_step = -1;
    err_step = -1;
    run_frame(PatWhite, 0);
    early_line = -1;
    check("early_err_latency", err_step - early_drive_step, 2);
    check("early_unlock_latency", unlock_step - early_drive_step, 2);
    check("early_no_done", fd_cnt, 0);
    check("early_relocked", cap.o_locked, 1);
    run_frame(PatWhite, 0);
    check_frame("after_early", 1152, 7040);
    check("sync_err_sticky", cap.o_sync_err, 1);

    // One-cycle reset mid-frame.
    rst_h = 30;
    rst_v = 15;
    rst_arm = 1;
    run_frame(PatWhite, 0);
    check("midreset_no_done", fd_cnt, 0);
    check("midreset_relocked", cap.o_locked, 1);
    run_frame(PatWhite, 0);
    check_frame("after_midreset", 1152, 7040);

    // Stimulus starting mid-frame after reset.
    reset = 1'b1;
    cap.i_pmod_in = 8'h88;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame(PatChk, VV / 2);
    check("midstart_no_done", fd_cnt, 0);
    check("midstart_locked", cap.o_locked, 1);
    run_frame(PatChk, 0);
    check_frame("checker", 576, 12096);

    // vsync falls together with the hsync edge of the last line before vsync.
    vs_early = 1;
    sim_watch = 1;
    run_frame(PatWhite, 0);
    vs_early = 0;
    sim_watch = 0;
    check("sim_seen", sim_hits, 1);
    check("sim_locked_end", cap.o_locked, 1);
    check("sim_no_err", cap.o_sync_err, 0);
    check_frame("sim", 1152, 7040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
